// File: rtl/float24_pkg.sv
// Format constants and the packed field layout for the 24-bit float type
// (1 sign, 7-bit biased exponent, 16-bit fraction with hidden leading 1).
package float24_pkg;

    localparam int SIGN_W   = 1;
    localparam int EXP_W    = 7;
    localparam int FRAC_W   = 16;
    localparam int FLOAT_W  = SIGN_W + EXP_W + FRAC_W;
    localparam int EXP_BIAS = 63;
    localparam int EXP_MAX  = 127;

    localparam int MANT_W   = FRAC_W + 1;
    localparam int PROD_W   = 2 * MANT_W;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } float24_t;

endpackage

// File: rtl/float24_mul.sv
// Combinational float24 multiply core: mantissa product, single-step
// normalisation, truncation, and exponent range classification.
module float24_mul
    import float24_pkg::*;
(
    input  float24_t i_a,
    input  float24_t i_b,
    output float24_t o_p,
    output logic     o_underflow,
    output logic     o_overflow
);

    localparam logic signed [9:0] C_BIAS    = 10'(EXP_BIAS);
    localparam logic signed [9:0] C_EXP_MAX = 10'(EXP_MAX);

    logic [MANT_W-1:0]  w_mant_a;
    logic [MANT_W-1:0]  w_mant_b;
    logic [PROD_W-1:0]  w_prod;
    logic               w_norm;
    logic [FRAC_W-1:0]  w_frac;
    logic signed [9:0]  w_exp;
    logic               w_sign;
    logic               w_zero;

    assign w_mant_a = {1'b1, i_a.frac};
    assign w_mant_b = {1'b1, i_b.frac};
    assign w_prod   = PROD_W'(w_mant_a) * PROD_W'(w_mant_b);
    assign w_norm   = w_prod[PROD_W-1];

    // Product of two [1,2) mantissas lies in [1,4); drop the leading 1 and truncate.
    assign w_frac   = w_norm ? w_prod[PROD_W-2 -: FRAC_W] : w_prod[PROD_W-3 -: FRAC_W];

    assign w_exp    = $signed({3'b000, i_a.exp}) + $signed({3'b000, i_b.exp})
                    - C_BIAS + $signed({9'b0, w_norm});
    assign w_sign   = i_a.sign ^ i_b.sign;
    assign w_zero   = (i_a.exp == '0) || (i_b.exp == '0);

    always_comb begin
        o_p         = '0;
        o_p.sign    = w_sign;
        o_underflow = 1'b0;
        o_overflow  = 1'b0;
        if (w_zero) begin
            o_p.exp = '0;
        end else if (w_exp > C_EXP_MAX) begin
            o_p.exp    = '1;
            o_p.frac   = '1;
            o_overflow = 1'b1;
        end else if (w_exp < 10'sd1) begin
            o_underflow = 1'b1;
        end else begin
            o_p.exp  = w_exp[EXP_W-1:0];
            o_p.frac = w_frac;
        end
    end

endmodule

// File: rtl/top_level.sv
// Two-stage pipelined float24 multiplier: operand registers, then the
// combinational core feeding the result/flag registers.
module top_level
    import float24_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [FLOAT_W-1:0] float_a,
    input  logic [FLOAT_W-1:0] float_b,
    output logic [FLOAT_W-1:0] float_out,
    output logic               float_out_underflow,
    output logic               float_out_overflow
);

    float24_t r_a;
    float24_t r_b;
    float24_t r_out;
    logic     r_underflow;
    logic     r_overflow;

    float24_t w_prod;
    logic     w_underflow;
    logic     w_overflow;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a <= '0;
            r_b <= '0;
        end else begin
            r_a <= float_a;
            r_b <= float_b;
        end
    end

    float24_mul u_mul (
        .i_a         (r_a),
        .i_b         (r_b),
        .o_p         (w_prod),
        .o_underflow (w_underflow),
        .o_overflow  (w_overflow)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out       <= '0;
            r_underflow <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_out       <= w_prod;
            r_underflow <= w_underflow;
            r_overflow  <= w_overflow;
        end
    end

    assign float_out           = r_out;
    assign float_out_underflow = r_underflow;
    assign float_out_overflow  = r_overflow;

endmodule

// File: tb/tb_top_level.sv
// Self-checking bench for the float24 pipelined multiplier; the reference
// model works on real-valued mantissas and integer exponents.
module tb_top_level;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [23:0] float_a = '0;
    logic [23:0] float_b = '0;
    logic [23:0] float_out;
    logic        float_out_underflow;
    logic        float_out_overflow;

    int checks = 0;
    int errors = 0;

    logic [23:0] va [7];
    logic [23:0] vb [7];
    logic [25:0] ve [7];

    top_level dut (
        .clk                 (clk),
        .rst                 (rst),
        .float_a             (float_a),
        .float_b             (float_b),
        .float_out           (float_out),
        .float_out_underflow (float_out_underflow),
        .float_out_overflow  (float_out_overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns {overflow, underflow, product} from the numeric definition of the format.
    function automatic logic [25:0] model(input logic [23:0] x, input logic [23:0] y);
        int   ea;
        int   eb;
        int   e;
        int   f;
        real  m;
        logic s;
        ea = int'(x[22:16]);
        eb = int'(y[22:16]);
        s  = x[23] ^ y[23];
        if (ea == 0 || eb == 0) return {2'b00, s, 23'b0};
        m = (1.0 + real'(x[15:0]) / 65536.0) * (1.0 + real'(y[15:0]) / 65536.0);
        e = ea + eb - 63;
        if (m >= 2.0) begin
            m = m / 2.0;
            e = e + 1;
        end
        if (e > 127) return {2'b10, s, 7'h7F, 16'hFFFF};
        if (e < 1)   return {2'b01, s, 23'b0};
        f = $rtoi((m - 1.0) * 65536.0);
        return {2'b00, s, e[6:0], f[15:0]};
    endfunction

    function automatic logic [23:0] rand_op();
        logic [23:0] v;
        v = 24'($urandom);
        if ($urandom_range(0, 7) == 0) v[22:16] = 7'd0;
        return v;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            float_a = rand_op();
            float_b = rand_op();
            step();
            checks++;
            if ({float_out_overflow, float_out_underflow, float_out} !== 26'h0) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got %h expected %h", i,
                         {float_out_overflow, float_out_underflow, float_out}, 26'h0);
            end
        end
        rst = 1'b1;
    endtask

    task automatic test_directed();
        logic [25:0] got;
        for (int i = 0; i < 7; i++) begin
            float_a = va[i];
            float_b = vb[i];
            step();
            step();
            got = {float_out_overflow, float_out_underflow, float_out};
            checks++;
            if (got !== ve[i]) begin
                errors++;
                $display("FAIL directed[%0d] a=%h b=%h: got %h expected %h",
                         i, va[i], vb[i], got, ve[i]);
            end
        end
    endtask

    task automatic test_back_to_back(input int n, input bit use_table);
        logic [25:0] q[$];
        logic [25:0] exp_v;
        logic [25:0] got;
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin
                float_a = use_table ? va[i % 7] : rand_op();
                float_b = use_table ? vb[i % 7] : rand_op();
                q.push_back(use_table ? ve[i % 7] : model(float_a, float_b));
            end
            step();
            if (i >= 1) begin
                exp_v = q.pop_front();
                got   = {float_out_overflow, float_out_underflow, float_out};
                checks++;
                if (got !== exp_v || (float_out_overflow && float_out_underflow)) begin
                    errors++;
                    $display("FAIL stream[%0d] table=%0d: got %h expected %h",
                             i - 1, use_table, got, exp_v);
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        logic [25:0] got;
        float_a = 24'h469040;
        float_b = 24'h3D8000;
        step();
        float_a = 24'h3754C9;
        float_b = 24'h470000;
        step();
        got = {float_out_overflow, float_out_underflow, float_out};
        checks++;
        if (got !== 26'h0452C30) begin
            errors++;
            $display("FAIL midflight_pre: got %h expected %h", got, 26'h0452C30);
        end
        #2 rst = 1'b0;
        #1;
        got = {float_out_overflow, float_out_underflow, float_out};
        checks++;
        if (got !== 26'h0) begin
            errors++;
            $display("FAIL async_clear: got %h expected %h", got, 26'h0);
        end
        step();
        step();
        rst = 1'b1;
        float_a = 24'h3D8000;
        float_b = 24'hBD8000;
        step();
        got = {float_out_overflow, float_out_underflow, float_out};
        checks++;
        if (got !== 26'h0) begin
            errors++;
            $display("FAIL post_release_stale: got %h expected %h", got, 26'h0);
        end
        step();
        got = {float_out_overflow, float_out_underflow, float_out};
        checks++;
        if (got !== model(24'h3D8000, 24'hBD8000)) begin
            errors++;
            $display("FAIL post_release_first: got %h expected %h",
                     got, model(24'h3D8000, 24'hBD8000));
        end
    endtask

    initial begin
        va[0] = 24'h469040; vb[0] = 24'h3D8000; ve[0] = {2'b00, 24'h452C30};
        va[1] = 24'h3754C9; vb[1] = 24'h470000; ve[1] = {2'b00, 24'h3F54C9};
        va[2] = 24'h7F0000; vb[2] = 24'h400000; ve[2] = {2'b10, 24'h7FFFFF};
        va[3] = 24'hFF0000; vb[3] = 24'h400000; ve[3] = {2'b10, 24'hFFFFFF};
        va[4] = 24'h000000; vb[4] = 24'h3E0000; ve[4] = {2'b00, 24'h000000};
        va[5] = 24'h010000; vb[5] = 24'h010000; ve[5] = {2'b01, 24'h000000};
        va[6] = 24'h800000; vb[6] = 24'h3F0000; ve[6] = {2'b00, 24'h800000};

        step();
        test_reset();
        test_directed();
        test_back_to_back(14, 1'b1);
        test_back_to_back(400, 1'b0);
        test_reset_midflight();
        test_back_to_back(100, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
